gate_vector_decoder: RTL and testbench
======================================

GATE_VECTOR_DECODER -- requirements
Module: gate_vector_decoder

Interface
REQ-001 The block SHALL have parameter ERR_LIMIT, default 3, giving the number of consecutive illegal vectors that forces LOCK (legal range 1..15).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_y holds a vector to decode.
REQ-005 in_ready  output  1  the block accepts in_y this cycle.
REQ-006 in_y  input  7 [0:6]  gate vector: bit0 AND, bit1 OR, bit2 NOT A, bit3 NAND, bit4 NOR, bit5 XOR, bit6 XNOR.
REQ-007 out_valid  output  1  the FIFO head is presented.
REQ-008 out_ready  input  1  the sink takes the head this cycle.
REQ-009 out_a, out_b  output  1 each  recovered operands.
REQ-010 out_err  output  1  the head word came from an illegal vector.
REQ-011 err_count  output  8  total illegal vectors accepted, saturating.
REQ-012 locked  output  1  the FSM is in LOCK.
REQ-013 clear_lock  input  1  single-cycle pulse that releases LOCK.

Function
REQ-014 A transfer SHALL occur on a rising edge only when in_valid=1 and in_ready=1; the output handshake likewise requires out_valid=1 and out_ready=1.
REQ-015 Only these vectors, written as in_y[0..6] for (A,B), SHALL be legal: 00 -> 0011101; 01 -> 0111010; 10 -> 0101010; 11 -> 1100001.
REQ-016 Decode SHALL set out_a = ~in_y[2] and out_b = in_y[5] ^ ~in_y[2] for every vector, legal or not, and err = (in_y is not legal).
REQ-017 Each accepted word {a, b, err} SHALL be pushed into a 2-entry FIFO; the head drives out_a, out_b and out_err.
REQ-018 Latency SHALL be 1 cycle: a word accepted at edge N into an empty FIFO makes out_valid=1 after edge N.
REQ-019 in_ready SHALL equal (state==RUN) && (occupancy<2), decoded from registers only; there is no combinational path from out_ready to in_ready.
REQ-020 A push and a pop on the same edge SHALL leave occupancy unchanged and preserve order.
REQ-021 out_valid SHALL equal (occupancy>0); out_a, out_b and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 The FSM SHALL have two states, RUN and LOCK, with locked = (state==LOCK).
REQ-023 A consecutive-error counter (4-bit) SHALL increment on each accepted illegal vector and clear on each accepted legal vector.
REQ-024 When an accepted illegal vector brings the consecutive-error counter to ERR_LIMIT, the FSM SHALL enter LOCK on that edge; the word itself is still pushed.
REQ-025 In LOCK, in_ready SHALL be 0 and the FIFO SHALL keep draining normally.
REQ-026 clear_lock=1 in LOCK SHALL return the FSM to RUN and zero the consecutive-error counter on that edge; clear_lock in RUN SHALL have no effect.
REQ-027 err_count SHALL increment by 1 on each accepted illegal vector, hold at 255, and be cleared only by reset (clear_lock does not clear it).

Reset
REQ-028 While rst_n=0, the block SHALL hold state=RUN, occupancy=0 (FIFO flushed), consecutive-error counter=0 and err_count=0.
REQ-029 During reset, outputs SHALL be out_valid=0, out_a=0, out_b=0, out_err=0, locked=0 and in_ready=0.
REQ-030 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered words; no partial word is ever presented.

Verification
REQ-032 With out_ready=1, drive legal vectors 0011101, 0111010, 0101010, 1100001 back to back -> (a,b) = 00, 01, 10, 11, each one cycle after acceptance, out_err=0, err_count=0.
REQ-033 Drive in_y=1111111 once, then legal vector 1100001 -> first output a=0, b=1, out_err=1; err_count=1; locked stays 0.
REQ-034 Hold out_ready=0 and offer 3 legal vectors -> 2 are accepted, in_ready=0 after the second, head stable; release out_ready -> words leave in order and the third is accepted.
REQ-035 With ERR_LIMIT=3, drive 3 consecutive illegal vectors -> locked=1 after the third edge, in_ready=0, all 3 outputs flagged out_err=1; pulse clear_lock -> RUN, in_ready=1, err_count stays 3.
REQ-036 Drive 260 illegal vectors with clear_lock pulsed as needed -> err_count saturates at 255.
REQ-037 Assert rst_n=0 with 2 words buffered and locked=1 -> out_valid=0, locked=0, err_count=0 immediately (asynchronous), and in_ready=1 one edge after release.

Source files
------------

// File: rtl/gate_vector_decoder.sv
// Decodes a 7-gate truth vector back to its (A,B) operands, flags illegal vectors and
// buffers results in a 2-entry FIFO; ERR_LIMIT consecutive illegal vectors lock the input.
module gate_vector_decoder #(
    parameter int unsigned ERR_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [0:6] in_y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_a,
    output logic       out_b,
    output logic       out_err,
    output logic [7:0] err_count,
    output logic       locked,
    input  logic       clear_lock
);

    typedef enum logic [0:0] {
        StRun,
        StLock
    } state_e;

    typedef struct packed {
        logic a;
        logic b;
        logic err;
    } word_t;

    localparam logic [3:0] LimitVal = 4'(ERR_LIMIT);

    state_e     r_state;
    logic [3:0] r_consec;
    logic [7:0] r_err_count;
    logic       r_init;

    word_t      r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic       w_legal;
    word_t      w_word;
    word_t      w_head;
    logic       w_push;
    logic       w_pop;
    logic [3:0] w_consec_inc;

    // Vectors are written in_y[0..6], so in_y[0] is the MSB of each literal.
    always_comb begin
        w_legal = (in_y == 7'b0011101) || (in_y == 7'b0111010) ||
                  (in_y == 7'b0101010) || (in_y == 7'b1100001);
        w_word.a   = ~in_y[2];
        w_word.b   = in_y[5] ^ ~in_y[2];
        w_word.err = ~w_legal;
    end

    assign w_push       = in_valid && in_ready;
    assign w_pop        = out_valid && out_ready;
    assign w_consec_inc = r_consec + 4'd1;
    assign w_head       = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // r_init keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_consec    <= 4'd0;
            r_err_count <= 8'd0;
            r_init      <= 1'b0;
        end else begin
            r_init <= 1'b1;
            case (r_state)
                StRun: begin
                    if (w_push) begin
                        if (w_legal) begin
                            r_consec <= 4'd0;
                        end else begin
                            r_consec <= w_consec_inc;
                            if (w_consec_inc == LimitVal) begin
                                r_state <= StLock;
                            end
                        end
                    end
                end
                StLock: begin
                    if (clear_lock) begin
                        r_state  <= StRun;
                        r_consec <= 4'd0;
                    end
                end
                default: r_state <= StRun;
            endcase
            if (w_push && !w_legal && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign in_ready  = r_init && (r_state == StRun) && (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_a     = out_valid & w_head.a;
    assign out_b     = out_valid & w_head.b;
    assign out_err   = out_valid & w_head.err;
    assign err_count = r_err_count;
    assign locked    = (r_state == StLock);

endmodule

// File: tb/tb_gate_vector_decoder.sv
// Directed table-driven bench for gate_vector_decoder (ERR_LIMIT = 3), plus hand sequences
// for error-count saturation and asynchronous reset with buffered words.
module tb_gate_vector_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [0:6] in_y;
    logic       out_valid;
    logic       out_ready;
    logic       out_a;
    logic       out_b;
    logic       out_err;
    logic [7:0] err_count;
    logic       locked;
    logic       clear_lock;

    int n_vec  = 0;
    int n_fail = 0;

    gate_vector_decoder #(.ERR_LIMIT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_err    (out_err),
        .err_count  (err_count),
        .locked     (locked),
        .clear_lock (clear_lock)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:6] y;
        logic       v;
        logic       ordy;
        logic       clr;
        logic       rdy;
        logic       ov;
        logic       a;
        logic       b;
        logic       e;
        logic       lk;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [0:6] y, input logic v, input logic ordy, input logic clr,
                       input logic rdy, input logic ov, input logic a, input logic b,
                       input logic e, input logic lk, input logic [7:0] ec);
        vec_t r;
        r.y = y; r.v = v; r.ordy = ordy; r.clr = clr;
        r.rdy = rdy; r.ov = ov; r.a = a; r.b = b; r.e = e; r.lk = lk; r.ec = ec;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic ov, input logic a,
                           input logic b, input logic e, input logic lk, input logic [7:0] ec);
        chk({tag, " in_ready"},  {7'd0, in_ready},  {7'd0, rdy});
        chk({tag, " out_valid"}, {7'd0, out_valid}, {7'd0, ov});
        chk({tag, " out_a"},     {7'd0, out_a},     {7'd0, a});
        chk({tag, " out_b"},     {7'd0, out_b},     {7'd0, b});
        chk({tag, " out_err"},   {7'd0, out_err},   {7'd0, e});
        chk({tag, " locked"},    {7'd0, locked},    {7'd0, lk});
        chk({tag, " err_count"}, err_count,         ec);
    endtask

    // Asserts reset off-edge, checks outputs at once, then releases and checks in_ready rise.
    task automatic do_reset(input string tag);
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_y       = 7'b0000000;
        out_ready  = 1'b1;
        clear_lock = 1'b0;
        #1;
        chk_all({tag, " in reset"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, " in_ready before first edge"}, {7'd0, in_ready}, 8'd0);
        @(posedge clk);
        #1;
        chk({tag, " in_ready after first edge"}, {7'd0, in_ready}, 8'd1);
        chk({tag, " out_valid after first edge"}, {7'd0, out_valid}, 8'd0);
    endtask

    task automatic drive_step(input logic [0:6] y, input logic v, input logic ordy,
                              input logic clr);
        in_y       = y;
        in_valid   = v;
        out_ready  = ordy;
        clear_lock = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       exp_lock;
        logic [3:0] exp_consec;
        logic [7:0] exp_ec;
        logic       exp_rdy;
        int         acc;
        int         guard;

        // y, v, ordy, clr | rdy, ov, a, b, e, lk, ec  (state after the edge)
        add(7'b0011101, 1, 1, 0,  1, 1, 0, 0, 0, 0, 8'd0);
        add(7'b0111010, 1, 1, 0,  1, 1, 0, 1, 0, 0, 8'd0);
        add(7'b0101010, 1, 1, 0,  1, 1, 1, 0, 0, 0, 8'd0);
        add(7'b1100001, 1, 1, 0,  1, 1, 1, 1, 0, 0, 8'd0);
        add(7'b0000000, 0, 1, 0,  1, 0, 0, 0, 0, 0, 8'd0);
        add(7'b1111111, 1, 1, 0,  1, 1, 0, 1, 1, 0, 8'd1);
        add(7'b1100001, 1, 1, 0,  1, 1, 1, 1, 0, 0, 8'd1);
        add(7'b0000000, 0, 1, 0,  1, 0, 0, 0, 0, 0, 8'd1);
        add(7'b0011101, 1, 0, 0,  1, 1, 0, 0, 0, 0, 8'd1);
        add(7'b0111010, 1, 0, 0,  0, 1, 0, 0, 0, 0, 8'd1);
        add(7'b0101010, 1, 0, 0,  0, 1, 0, 0, 0, 0, 8'd1);
        add(7'b0101010, 1, 1, 0,  1, 1, 0, 1, 0, 0, 8'd1);
        add(7'b0101010, 1, 1, 0,  1, 1, 1, 0, 0, 0, 8'd1);
        add(7'b0000000, 0, 1, 0,  1, 0, 0, 0, 0, 0, 8'd1);
        add(7'b1111111, 1, 1, 0,  1, 1, 0, 1, 1, 0, 8'd2);
        add(7'b1000000, 1, 1, 0,  1, 1, 1, 1, 1, 0, 8'd3);
        add(7'b0000000, 1, 1, 0,  0, 1, 1, 1, 1, 1, 8'd4);
        add(7'b0011101, 1, 1, 0,  0, 0, 0, 0, 0, 1, 8'd4);
        add(7'b0000000, 0, 1, 1,  1, 0, 0, 0, 0, 0, 8'd4);
        add(7'b1111111, 1, 1, 0,  1, 1, 0, 1, 1, 0, 8'd5);
        add(7'b1111111, 1, 1, 0,  1, 1, 0, 1, 1, 0, 8'd6);
        add(7'b0011101, 1, 1, 0,  1, 1, 0, 0, 0, 0, 8'd6);
        add(7'b1111111, 1, 1, 0,  1, 1, 0, 1, 1, 0, 8'd7);
        add(7'b1111111, 1, 1, 0,  1, 1, 0, 1, 1, 0, 8'd8);
        add(7'b0000000, 0, 1, 0,  1, 0, 0, 0, 0, 0, 8'd8);
        add(7'b0000000, 0, 1, 1,  1, 0, 0, 0, 0, 0, 8'd8);
        add(7'b1111111, 1, 1, 0,  0, 1, 0, 1, 1, 1, 8'd9);
        add(7'b0000000, 0, 1, 0,  0, 0, 0, 0, 0, 1, 8'd9);
        add(7'b0000000, 0, 1, 1,  1, 0, 0, 0, 0, 0, 8'd9);

        do_reset("reset0");

        for (int i = 0; i < tbl.size(); i++) begin
            drive_step(tbl[i].y, tbl[i].v, tbl[i].ordy, tbl[i].clr);
            chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].ov, tbl[i].a, tbl[i].b,
                    tbl[i].e, tbl[i].lk, tbl[i].ec);
        end

        // Saturation: keep offering illegal vectors, clearing the lock whenever it trips.
        do_reset("reset1");
        exp_lock   = 1'b0;
        exp_consec = 4'd0;
        exp_ec     = 8'd0;
        acc        = 0;
        guard      = 0;
        while (acc < 260 && guard < 2000) begin
            guard++;
            exp_rdy = !exp_lock;
            chk($sformatf("sat%0d in_ready", guard), {7'd0, in_ready}, {7'd0, exp_rdy});
            drive_step(7'b1111111, 1'b1, 1'b1, exp_lock);
            if (exp_rdy) begin
                acc++;
                if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
                exp_consec = exp_consec + 4'd1;
                if (exp_consec == 4'd3) exp_lock = 1'b1;
            end else if (exp_lock) begin
                exp_lock   = 1'b0;
                exp_consec = 4'd0;
            end
            chk($sformatf("sat%0d locked", guard), {7'd0, locked}, {7'd0, exp_lock});
            chk($sformatf("sat%0d err_count", guard), err_count, exp_ec);
        end
        chk("sat accepted count reached", {7'd0, acc >= 260}, 8'd1);
        chk("sat err_count final", err_count, 8'd255);

        // Two words buffered while locked, then asynchronous reset.
        do_reset("reset2");
        drive_step(7'b1111111, 1'b1, 1'b0, 1'b0);
        chk_all("buf1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
        drive_step(7'b1111111, 1'b1, 1'b1, 1'b0);
        chk_all("buf2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
        drive_step(7'b1111111, 1'b1, 1'b0, 1'b0);
        chk_all("buf3", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3);
        in_valid = 1'b0;
        #2;
        do_reset("reset3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
